// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep sliced add/sub pipeline with valid/ready flow control.
// Define PIPELINED_ADDER_OVF_EN to build the signed overflow flag; otherwise overflow is tied to 0.
module pipelined_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] first,
   input  logic [WIDTH-1:0] second,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic             out_valid,
   input  logic             out_ready
);
   localparam int S = WIDTH / STAGES;
   logic w_en;
   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int R = WIDTH - k * S;
      logic [R-1:0] w_a, w_b;
      logic w_ci, w_vi;
      logic [S:0] w_r;
      logic [(k+1)*S-1:0] w_n, r_s;
      logic r_c, r_v;
      if (k == 0) begin : g_src
         assign w_a  = first;
         assign w_b  = sub ? ~second : second;
         assign w_ci = sub;
         assign w_vi = in_valid;
         assign w_n  = w_r[S-1:0];
      end else begin : g_src
         assign w_a  = g_st[k-1].g_fw.r_a;
         assign w_b  = g_st[k-1].g_fw.r_b;
         assign w_ci = g_st[k-1].r_c;
         assign w_vi = g_st[k-1].r_v;
         assign w_n  = {w_r[S-1:0], g_st[k-1].r_s};
      end
      assign w_r = {1'b0, w_a[S-1:0]} + {1'b0, w_b[S-1:0]} + {{S{1'b0}}, w_ci};
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            r_v <= 1'b0;
            r_c <= 1'b0;
            r_s <= '0;
         end else if (w_en) begin
            r_v <= w_vi;
            r_c <= w_r[S];
            r_s <= w_n;
         end
      // operand slices not yet consumed ride along with the beat
      if (k < STAGES - 1) begin : g_fw
         logic [R-S-1:0] r_a, r_b;
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_en) begin
               r_a <= w_a[R-1:S];
               r_b <= w_b[R-1:S];
            end
      end
   end
   assign out_valid = g_st[STAGES-1].r_v;
   assign sum       = g_st[STAGES-1].r_s;
   assign carry_out = g_st[STAGES-1].r_c;
   assign w_en      = !out_valid || out_ready;
   assign in_ready  = w_en;
`ifdef PIPELINED_ADDER_OVF_EN
   logic r_o;
   // carry into the MSB recovered as sum^a^b at that bit, then XOR carry out
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         r_o <= 1'b0;
      else if (w_en)
         r_o <= g_st[STAGES-1].w_r[S] ^ g_st[STAGES-1].w_n[WIDTH-1]
              ^ g_st[STAGES-1].w_a[S-1] ^ g_st[STAGES-1].w_b[S-1];
   assign overflow = r_o;
`else
   assign overflow = 1'b0;
`endif
endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, meaning pipeline depth; WIDTH SHALL be an integer multiple of STAGES, and STAGES SHALL be >= 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operand beat offered.
REQ-006 SHALL have port in_ready, output, 1 bit: beat accepted when in_valid and in_ready are both high at a clock edge.
REQ-007 SHALL have port first, input, WIDTH bits: operand A.
REQ-008 SHALL have port second, input, WIDTH bits: operand B.
REQ-009 SHALL have port sub, input, 1 bit: 0 computes A+B, 1 computes A-B.
REQ-010 SHALL have port sum, output, WIDTH bits: result.
REQ-011 SHALL have port carry_out, output, 1 bit: carry out of the MSB; for subtraction, 1 means no borrow.
REQ-012 SHALL have port overflow, output, 1 bit: two's-complement signed overflow flag.
REQ-013 SHALL have port out_valid, output, 1 bit: result beat present.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer accepts the result beat when out_valid and out_ready are both high.

Function
REQ-015 SHALL split operands into STAGES slices of WIDTH/STAGES bits; stage k adds slice k, taking carry-in from stage k-1's registered carry.
REQ-016 SHALL, on sub=1, add the bitwise inverse of second with carry-in 1 into slice 0; on sub=0, use carry-in 0.
REQ-017 SHALL delay operand slices that are not yet consumed alongside the beat; completed result slices SHALL travel with the beat to the output.
REQ-018 SHALL produce sum = (first + second) mod 2^WIDTH or (first - second) mod 2^WIDTH; no truncation beyond WIDTH.
REQ-019 SHALL compute overflow as the carry into the MSB XOR the carry out of the MSB, evaluated in the final stage.
REQ-020 SHALL, with no stall, assert out_valid exactly STAGES cycles after the accepting edge; throughput is one beat per cycle.
REQ-021 SHALL derive a single pipeline advance enable = !out_valid || out_ready; in_ready SHALL equal this enable combinationally.
REQ-022 SHALL hold every stage register, and sum, carry_out, overflow and out_valid, stable while the enable is low.
REQ-023 SHALL carry a per-stage valid bit; bubbles propagate as invalid and are not collapsed.
REQ-024 SHALL, when out_valid and out_ready are high and a new beat is accepted on the same edge, keep both transfers with no beat lost or duplicated.
REQ-025 SHALL, for STAGES=1, degenerate to a single registered adder with 1-cycle latency.

Reset
REQ-026 SHALL, while rst_n is low, immediately clear all stage valid bits, out_valid, sum, carry_out and overflow to 0, independent of clk.
REQ-027 SHALL drive in_ready to 1 during and after reset, because out_valid is 0.
REQ-028 SHALL discard all in-flight beats when reset asserts mid-operation; after release, the first out_valid SHALL occur only for a beat accepted after release.

Configuration
REQ-029 SHALL compile overflow detection in when macro PIPELINED_ADDER_OVF_EN is defined, with overflow driven as in REQ-019.
REQ-030 SHALL, when PIPELINED_ADDER_OVF_EN is undefined, tie overflow to constant 0, remove overflow logic, and leave the port list unchanged.

Verification
REQ-031 SHALL cover: first=45, second=89654, sub=0, out_ready=1 -> sum=89699, carry_out=0, out_valid exactly 4 cycles later.
REQ-032 SHALL cover: back-to-back beats (0+65498), (7984+12365) on consecutive cycles -> sum=65498 then 20349 on consecutive cycles.
REQ-033 SHALL cover: first=5, second=7, sub=1 -> sum=0xFFFFFFFE, carry_out=0, overflow=0; and first=7, second=5, sub=1 -> sum=2, carry_out=1.
REQ-034 SHALL cover: first=0x7FFFFFFF, second=1, sub=0 -> sum=0x80000000, overflow=1 with macro defined and overflow=0 without it.
REQ-035 SHALL cover: out_ready held 0 for 3 cycles with the pipe full -> in_ready=0 and sum/out_valid stable; on release, results drain in order with none lost.
REQ-036 SHALL cover: rst_n pulsed low with 3 beats in flight -> out_valid=0 immediately, and no stale result appears after release.
